// File: rtl/keypad_scanner_pkg.sv
// Shared definitions for the keypad scanner: key codes, the internal
// multi-key marker, the key map and a constant clog2 helper.
// Optional feature macro used by this slice: KEYPAD_STROBE_EN.
package keypad_scanner_pkg;

    localparam logic [4:0] KEY_0     = 5'd0;
    localparam logic [4:0] KEY_1     = 5'd1;
    localparam logic [4:0] KEY_2     = 5'd2;
    localparam logic [4:0] KEY_3     = 5'd3;
    localparam logic [4:0] KEY_4     = 5'd4;
    localparam logic [4:0] KEY_5     = 5'd5;
    localparam logic [4:0] KEY_6     = 5'd6;
    localparam logic [4:0] KEY_7     = 5'd7;
    localparam logic [4:0] KEY_8     = 5'd8;
    localparam logic [4:0] KEY_9     = 5'd9;
    localparam logic [4:0] KEY_A     = 5'd10;
    localparam logic [4:0] KEY_B     = 5'd11;
    localparam logic [4:0] KEY_C     = 5'd12;
    localparam logic [4:0] KEY_D     = 5'd13;
    localparam logic [4:0] KEY_E     = 5'd14;
    localparam logic [4:0] KEY_F     = 5'd15;
    localparam logic [4:0] KEY_NONE  = 5'd16;
    // Never leaves the scanner: marks a scan that saw two or more keys.
    localparam logic [4:0] KEY_MULTI = 5'h1F;

    // Bits needed to hold values 0..value-1, never less than one.
    function automatic int clog2(input int value);
        int width;
        width = 0;
        while ((1 << width) < value) width++;
        if (width < 1) width = 1;
        return width;
    endfunction

    // Physical keypad layout, row r / column c.
    function automatic logic [4:0] key_map(input logic [1:0] row, input logic [1:0] col);
        logic [4:0] code;
        case ({row, col})
            4'h0: code = KEY_1;
            4'h1: code = KEY_2;
            4'h2: code = KEY_3;
            4'h3: code = KEY_A;
            4'h4: code = KEY_4;
            4'h5: code = KEY_5;
            4'h6: code = KEY_6;
            4'h7: code = KEY_B;
            4'h8: code = KEY_7;
            4'h9: code = KEY_8;
            4'hA: code = KEY_9;
            4'hB: code = KEY_C;
            4'hC: code = KEY_E;
            4'hD: code = KEY_0;
            4'hE: code = KEY_F;
            default: code = KEY_D;
        endcase
        return code;
    endfunction

endpackage

// File: rtl/keypad_scanner_key_debouncer.sv
// Debounces full-scan results into the stable key code.
// With KEYPAD_STROBE_EN defined, also emits a one-cycle key_strobe on
// every new non-NONE key.
//
//   state     | meaning
//   ----------+----------------------------------------------------------
//   ST_STABLE | key matches the scans; waiting for a differing result
//   ST_CHECK  | counting consecutive scans equal to the candidate code
module key_debouncer
    import keypad_scanner_pkg::*;
#(
    parameter int DEBOUNCE_SCANS = 4
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [4:0] scan_result,
    input  logic       scan_valid,
`ifdef KEYPAD_STROBE_EN
    output logic       key_strobe,
`endif
    output logic [4:0] key
);

    localparam int CNT_W = clog2(DEBOUNCE_SCANS + 1);
    localparam logic [CNT_W-1:0] CNT_MAX = '1;
    localparam logic [CNT_W-1:0] CNT_DONE = CNT_W'(DEBOUNCE_SCANS);

    localparam logic [0:0] ST_STABLE = 1'b0;
    localparam logic [0:0] ST_CHECK  = 1'b1;

    logic [0:0]       state, state_nx;
    logic [4:0]       cand, cand_nx;
    logic [CNT_W-1:0] cnt, cnt_nx;
    logic [4:0]       key_nx;
`ifdef KEYPAD_STROBE_EN
    logic             strobe_nx;
`endif

    // Next-state decode; only a valid scan result moves anything.
    always_comb begin
        state_nx = state;
        cand_nx  = cand;
        cnt_nx   = cnt;
        key_nx   = key;
`ifdef KEYPAD_STROBE_EN
        strobe_nx = 1'b0;
`endif
        if (scan_valid) begin
            case (state)
                ST_STABLE: begin
                    if (scan_result != key) begin
                        cand_nx  = scan_result;
                        cnt_nx   = CNT_W'(1);
                        state_nx = ST_CHECK;
                    end else begin
                        cnt_nx = '0;
                    end
                end
                default: begin
                    if (scan_result == cand) begin
                        cnt_nx = (cnt == CNT_MAX) ? cnt : cnt + CNT_W'(1);
                    end else begin
                        cand_nx = scan_result;
                        cnt_nx  = CNT_W'(1);
                    end
                end
            endcase
            // A run that reaches the target commits, except a multi-key
            // run which is simply dropped.
            if (state_nx == ST_CHECK && cnt_nx >= CNT_DONE) begin
                if (cand_nx != KEY_MULTI) begin
                    key_nx = cand_nx;
`ifdef KEYPAD_STROBE_EN
                    strobe_nx = (cand_nx != KEY_NONE) && (cand_nx != key);
`endif
                end
                state_nx = ST_STABLE;
                cnt_nx   = '0;
            end
        end
    end

    // Debouncer state registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= ST_STABLE;
            cand  <= KEY_NONE;
            cnt   <= '0;
            key   <= KEY_NONE;
`ifdef KEYPAD_STROBE_EN
            key_strobe <= 1'b0;
`endif
        end else begin
            state <= state_nx;
            cand  <= cand_nx;
            cnt   <= cnt_nx;
            key   <= key_nx;
`ifdef KEYPAD_STROBE_EN
            key_strobe <= strobe_nx;
`endif
        end
    end

endmodule

// File: rtl/keypad_scanner.sv
// 4x4 active-low keypad scanner: column synchronizer, row divider and
// drive, per-scan hit encoding, feeding key_debouncer.
// Optional macro KEYPAD_STROBE_EN adds the key_strobe output.
module keypad_scanner
    import keypad_scanner_pkg::*;
#(
    parameter int SCAN_DIV       = 10000,
    parameter int DEBOUNCE_SCANS = 4
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [3:0] col_n,
    output logic [3:0] row_n,
`ifdef KEYPAD_STROBE_EN
    output logic       key_strobe,
`endif
    output logic [4:0] key
);

    localparam int DIV_W = clog2(SCAN_DIV);
    localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(SCAN_DIV - 1);

    logic [3:0]       col_s1, col_s2;
    logic [DIV_W-1:0] div_cnt;
    logic [1:0]       row_idx;
    logic             row_last;
    logic [11:0]      hit_lo;
    logic [15:0]      all_hits;
    logic [4:0]       hit_count;
    logic [4:0]       hit_code;
    logic [4:0]       scan_comb;
    logic [4:0]       scan_result;
    logic             scan_valid;

    assign row_last = (div_cnt == DIV_LAST);

    // Two-flop synchronizer for the asynchronous column inputs.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            col_s1 <= 4'b1111;
            col_s2 <= 4'b1111;
        end else begin
            col_s1 <= col_n;
            col_s2 <= col_s1;
        end
    end

    // Row dwell divider and one-cold row drive, rotating 0->3->0.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            div_cnt <= '0;
            row_idx <= 2'd0;
            row_n   <= 4'b1110;
        end else if (row_last) begin
            div_cnt <= '0;
            row_idx <= row_idx + 2'd1;
            row_n   <= ~(4'b0001 << (row_idx + 2'd1));
        end else begin
            div_cnt <= div_cnt + DIV_W'(1);
        end
    end

    // Latch hits for rows 0..2; row 3 is taken live at end of scan.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            hit_lo <= '0;
        end else if (row_last) begin
            case (row_idx)
                2'd0:    hit_lo[3:0]  <= ~col_s2;
                2'd1:    hit_lo[7:4]  <= ~col_s2;
                2'd2:    hit_lo[11:8] <= ~col_s2;
                default: hit_lo       <= hit_lo;
            endcase
        end
    end

    // Encode the whole scan: none, the single key, or multi.
    always_comb begin
        all_hits  = {~col_s2, hit_lo};
        hit_count = '0;
        hit_code  = KEY_NONE;
        for (int i = 0; i < 16; i++) begin
            if (all_hits[i]) begin
                hit_count = hit_count + 5'd1;
                hit_code  = key_map(2'(i / 4), 2'(i % 4));
            end
        end
        if (hit_count == 5'd0) begin
            scan_comb = KEY_NONE;
        end else if (hit_count == 5'd1) begin
            scan_comb = hit_code;
        end else begin
            scan_comb = KEY_MULTI;
        end
    end

    // Register the scan result with a one-cycle valid pulse.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            scan_result <= KEY_NONE;
            scan_valid  <= 1'b0;
        end else begin
            scan_valid <= row_last && (row_idx == 2'd3);
            if (row_last && (row_idx == 2'd3)) begin
                scan_result <= scan_comb;
            end
        end
    end

    key_debouncer #(
        .DEBOUNCE_SCANS(DEBOUNCE_SCANS)
    ) u_debouncer (
        .clk         (clk),
        .rst         (rst),
        .scan_result (scan_result),
        .scan_valid  (scan_valid),
`ifdef KEYPAD_STROBE_EN
        .key_strobe  (key_strobe),
`endif
        .key         (key)
    );

endmodule

// File: tb/tb_keypad_scanner.sv
// Bench for keypad_scanner: a keypad model drives col_n from a set of
// pressed keys; a reference model judges each full scan and debounces by
// looking at the most recent scan results.
module tb_keypad_scanner;

    localparam int SCAN_DIV = 4;
    localparam int DEB      = 2;

    logic       clk = 1'b0;
    logic       rst;
    logic [3:0] col_n;
    logic [3:0] row_n;
    logic [4:0] key;
`ifdef KEYPAD_STROBE_EN
    logic       key_strobe;
`endif

    logic [15:0] pressed;
    int          n_asserts = 0;
    int          n_fail    = 0;
    int          cyc       = 0;
    logic [4:0]  mkey;
    bit          pend;
    logic [4:0]  hist[$];
    int          keymap[16] = '{1, 2, 3, 10, 4, 5, 6, 11, 7, 8, 9, 12, 14, 0, 15, 13};

    localparam logic [15:0] P1 = 16'h0001;
    localparam logic [15:0] P6 = 16'h0040;
    localparam logic [15:0] P8 = 16'h0200;
    localparam logic [15:0] PD = 16'h8000;

    always #5 clk = ~clk;

    keypad_scanner #(
        .SCAN_DIV       (SCAN_DIV),
        .DEBOUNCE_SCANS (DEB)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .col_n      (col_n),
        .row_n      (row_n),
`ifdef KEYPAD_STROBE_EN
        .key_strobe (key_strobe),
`endif
        .key        (key)
    );

    // Keypad: a pressed key shorts its column to a row being driven low.
    always_comb begin
        col_n = 4'hF;
        for (int r = 0; r < 4; r++)
            for (int c = 0; c < 4; c++)
                if (pressed[r*4+c] && !row_n[r]) col_n[c] = 1'b0;
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_asserts++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        cyc  = 0;
        mkey = 5'd16;
        pend = 1'b0;
        hist.delete();
    endtask

    // One clock; check row drive, key and strobe against the model.
    task automatic step_chk();
        logic [3:0] exp_row;
        @(posedge clk);
        #1;
        cyc++;
        exp_row = 4'b1111;
        exp_row[(cyc / 4) % 4] = 1'b0;
        chk("row_n", row_n, exp_row);
        chk("key", key, mkey);
`ifdef KEYPAD_STROBE_EN
        chk("key_strobe", key_strobe, pend);
`endif
        pend = 1'b0;
    endtask

    // Judge one full scan with pressed set p; the key reacts one cycle later.
    task automatic model_scan(input logic [15:0] p);
        logic [4:0] res;
        bit         same;
        int         n;
        int         idx;
        n   = $countones(p);
        idx = 0;
        for (int i = 0; i < 16; i++) if (p[i]) idx = i;
        if (n == 0)      res = 5'd16;
        else if (n == 1) res = 5'(keymap[idx]);
        else             res = 5'h1F;
        hist.push_back(res);
        if (hist.size() > DEB) void'(hist.pop_front());
        same = (hist.size() == DEB);
        for (int i = 0; i < hist.size(); i++) if (hist[i] != res) same = 1'b0;
        if (same && res != 5'h1F && res != mkey) begin
            pend = (res != 5'd16);
            mkey = res;
        end
    endtask

    // Hold p for one full scan; optionally check key on its first cycle.
    task automatic run_scan(input logic [15:0] p, input bit dir, input logic [4:0] exp_first);
        pressed = p;
        for (int i = 0; i < 16; i++) begin
            step_chk();
            if (i == 0 && dir) chk("directed_key", key, exp_first);
        end
        model_scan(p);
    endtask

    initial begin
        logic [15:0] prev;
        logic [15:0] p;
        int          sel;

        pressed = '0;
        rst = 1'b1;
        model_reset();
        repeat (3) @(posedge clk);
        #1;
        chk("reset_row_n", row_n, 4'b1110);
        chk("reset_key", key, 5'd16);
`ifdef KEYPAD_STROBE_EN
        chk("reset_strobe", key_strobe, 1'b0);
`endif
        @(negedge clk);
        rst = 1'b0;

        // Idle scans: row rotation and KEY_NONE.
        run_scan('0, 1, 5'd16);
        run_scan('0, 1, 5'd16);

        // Press 6: key changes after the second matching scan.
        run_scan(P6, 1, 5'd16);
        run_scan(P6, 1, 5'd16);
        run_scan(P6, 1, 5'd6);

        // Release: two NONE scans before KEY_NONE.
        run_scan('0, 1, 5'd6);
        run_scan('0, 1, 5'd6);
        run_scan('0, 1, 5'd16);

        // Bounce: held, released, held twice.
        run_scan(P6, 1, 5'd16);
        run_scan('0, 1, 5'd16);
        run_scan(P6, 1, 5'd16);
        run_scan(P6, 1, 5'd16);
        run_scan('0, 1, 5'd6);
        run_scan('0, 1, 5'd6);
        run_scan('0, 1, 5'd16);

        // Keys 1 and 8 together never reach key; then 1 alone does.
        run_scan(P1 | P8, 1, 5'd16);
        run_scan(P1 | P8, 1, 5'd16);
        run_scan(P1 | P8, 1, 5'd16);
        run_scan(P1 | P8, 1, 5'd16);
        run_scan(P1, 1, 5'd16);
        run_scan(P1, 1, 5'd16);

        // Press D straight from 1, reset during its second scan.
        run_scan(PD, 1, 5'd1);
        pressed = PD;
        for (int i = 0; i < 6; i++) step_chk();
        chk("pre_reset_key", key, 5'd1);
        #2;
        rst = 1'b1;
        #1;
        chk("midrst_key", key, 5'd16);
        chk("midrst_row_n", row_n, 4'b1110);
`ifdef KEYPAD_STROBE_EN
        chk("midrst_strobe", key_strobe, 1'b0);
`endif
        @(negedge clk);
        rst = 1'b0;
        model_reset();
        run_scan(PD, 1, 5'd16);
        run_scan(PD, 1, 5'd16);
        run_scan('0, 1, 5'd13);

        // Random presses, holds, releases and double presses.
        prev = '0;
        repeat (40) begin
            sel = int'($urandom_range(0, 9));
            if (sel < 4)      p = prev;
            else if (sel < 6) p = '0;
            else if (sel < 9) p = 16'(1) << $urandom_range(0, 15);
            else              p = (16'(1) << $urandom_range(0, 15)) | (16'(1) << $urandom_range(0, 15));
            prev = p;
            run_scan(p, 0, 5'd0);
        end
        step_chk();

        $display("End of test - %0d assertions evaluated, %0d failures", n_asserts, n_fail);
        $finish;
    end

endmodule
